// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit controller.
// Width codes, FSM states, RAM base address and an alignment-mask helper.
package lsu_pkg;

   typedef enum logic [1:0] {
      WDT_B = 2'b00,
      WDT_H = 2'b01,
      WDT_W = 2'b10,
      WDT_D = 2'b11
   } wdt_e;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT,
      RESP
   } state_e;

   localparam logic [63:0] RamAddr = 64'h0000_0000_8000_0000;

   // Address bits that must be zero for an access of the given width.
   function automatic logic [63:0] lsb_mask(input wdt_e w);
      case (w)
         WDT_B:   return 64'h0;
         WDT_H:   return 64'h1;
         WDT_W:   return 64'h3;
         default: return 64'h7;
      endcase
   endfunction

endpackage

// File: rtl/lsu_sext.sv
// Load-result extension: sign-extends 8/16/32-bit data when requested.
// 64-bit data and unsigned loads pass through unchanged.
module lsu_sext
   import lsu_pkg::*;
(
   input  logic [63:0] data,
   input  logic [1:0]  wdt,
   input  logic        sext,
   output logic [63:0] result
);

   wdt_e w;
   assign w = wdt_e'(wdt);

   always_comb begin
      result = data;
      if (sext) begin
         case (w)
            WDT_B:   result = {{56{data[7]}},  data[7:0]};
            WDT_H:   result = {{48{data[15]}}, data[15:0]};
            WDT_W:   result = {{32{data[31]}}, data[31:0]};
            default: result = data;
         endcase
      end
   end

endmodule

// File: rtl/lsu_ctrl.sv
// Single-outstanding load/store controller between EXU, memory and WBU.
// Define LSU_MISALIGN_TRAP_EN to flag misaligned accesses instead of aligning them.
module lsu_ctrl
   import lsu_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_wen,
   input  logic [63:0] req_addr,
   input  logic [63:0] req_wdata,
   input  logic [1:0]  req_wdt,
   input  logic        req_sext,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [63:0] rsp_rdata,
   output logic        rsp_misalign,
   output logic        mem_ren,
   output logic        mem_wen,
   output logic [63:0] mem_raddr,
   output logic [63:0] mem_waddr,
   output logic [63:0] mem_wdata,
   output logic [1:0]  mem_wdt,
   input  logic [63:0] mem_rdata
);

   state_e      state_q, state_d;
   logic        wen_q, sext_q;
   wdt_e        wdt_q;
   logic [63:0] addr_q, wdata_q, rdata_q;
   logic [63:0] addr_in, sext_out;
   logic        fire, misaligned;

   assign fire = req_valid & req_ready;

`ifdef LSU_MISALIGN_TRAP_EN
   logic mis_q;
   assign addr_in      = req_addr;
   assign misaligned   = |(addr_q & lsb_mask(wdt_q));
   assign rsp_misalign = mis_q;
`else
   assign addr_in      = req_addr & ~lsb_mask(wdt_e'(req_wdt));
   assign misaligned   = 1'b0;
   assign rsp_misalign = 1'b0;
`endif

   lsu_sext u_sext (
      .data   (mem_rdata),
      .wdt    (wdt_q),
      .sext   (sext_q),
      .result (sext_out)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         wen_q   <= 1'b0;
         sext_q  <= 1'b0;
         wdt_q   <= WDT_B;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
         mis_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         if (fire) begin
            wen_q   <= req_wen;
            sext_q  <= req_sext;
            wdt_q   <= wdt_e'(req_wdt);
            addr_q  <= addr_in;
            wdata_q <= req_wdata;
            rdata_q <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
            mis_q   <= 1'b0;
`endif
         end
`ifdef LSU_MISALIGN_TRAP_EN
         if (state_q == ISSUE && misaligned) mis_q <= 1'b1;
`endif
         if (state_q == WAIT) rdata_q <= sext_out;
      end
   end

   always_comb begin
      state_d   = state_q;
      req_ready = 1'b0;
      rsp_valid = 1'b0;
      mem_ren   = 1'b0;
      mem_wen   = 1'b0;
      case (state_q)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) state_d = ISSUE;
         end
         ISSUE: begin
            if (misaligned) begin
               state_d = RESP;
            end else if (wen_q) begin
               mem_wen = 1'b1;
               state_d = RESP;
            end else begin
               mem_ren = 1'b1;
               state_d = WAIT;
            end
         end
         WAIT: state_d = RESP;
         RESP: begin
            rsp_valid = 1'b1;
            if (rsp_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      // Handshake and strobe outputs are suppressed while reset is asserted.
      if (rst) begin
         req_ready = 1'b0;
         rsp_valid = 1'b0;
         mem_ren   = 1'b0;
         mem_wen   = 1'b0;
      end
   end

   assign rsp_rdata = rdata_q;
   assign mem_raddr = addr_q;
   assign mem_waddr = addr_q;
   assign mem_wdata = wdata_q;
   assign mem_wdt   = wdt_q;

endmodule
